qspi_io_phy: RTL and testbench

Parametrised QSPI/OSPI bidirectional I/O controller, the next generation of the QSPI pad-control block. Sits between the shift register and the package pins: drives 1/2/4/8 lanes on `drive_edge` and captures read data on `sample_edge`. Adds what the previous block lacked: octal mode, a direction state machine with programmable bus-turnaround cycles, a registered capture path with a valid strobe, and invalid-mode detection.

---
 rtl/qspi_pkg.sv | 41 ++++
 rtl/qspi_io_capture.sv | 48 ++++
 rtl/qspi_io_phy.sv | 121 ++++++++++++
 tb/tb_qspi_io_phy.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared QSPI pad-control definitions: mode codes, direction codes, FSM states, lane masks.
// No logic of its own; no latency or flow control.
// Helper functions take the physical lane count so one package serves 4- and 8-lane builds.
package qspi_pkg;

    localparam logic [2:0] MODE_ZERO   = 3'b000;
    localparam logic [2:0] MODE_SINGLE = 3'b001;
    localparam logic [2:0] MODE_DUAL   = 3'b010;
    localparam logic [2:0] MODE_QUAD   = 3'b011;
    localparam logic [2:0] MODE_OCTAL  = 3'b100;

    localparam logic DIR_WRITE = 1'b0;
    localparam logic DIR_READ  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_TURN  = 2'd3
    } io_state_t;

    // Octal needs eight physical lanes; on a 4-lane build it is treated as invalid.
    function automatic logic mode_is_valid(input logic [2:0] mode, input int io_width);
        case (mode)
            MODE_ZERO, MODE_SINGLE, MODE_DUAL, MODE_QUAD: mode_is_valid = 1'b1;
            MODE_OCTAL:                                   mode_is_valid = (io_width >= 8);
            default:                                      mode_is_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] mode_to_mask(input logic [2:0] mode, input int io_width);
        case (mode)
            MODE_SINGLE: mode_to_mask = 8'h01;
            MODE_DUAL:   mode_to_mask = 8'h03;
            MODE_QUAD:   mode_to_mask = 8'h0F;
            MODE_OCTAL:  mode_to_mask = (io_width >= 8) ? 8'hFF : 8'h00;
            default:     mode_to_mask = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/qspi_io_capture.sv
// Read-data capture register(s) with a one-cycle valid strobe per sample.
// Latency: 1 cycle after capture, 2 when QSPI_IO_SAMPLE_PIPE_EN is defined.
// No backpressure: every capture request produces exactly one valid pulse.
module qspi_io_capture #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         capture,
    input  logic [W-1:0] sample_dat,
    output logic [W-1:0] data_in,
    output logic         data_in_valid
);

`ifdef QSPI_IO_SAMPLE_PIPE_EN
    // First stage sits right behind the pads; the second stage feeds the core.
    logic [W-1:0] stage_dat;
    logic         stage_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_dat     <= '0;
            stage_vld     <= 1'b0;
            data_in       <= '0;
            data_in_valid <= 1'b0;
        end else begin
            stage_vld     <= capture;
            data_in_valid <= stage_vld;
            if (capture)
                stage_dat <= sample_dat;
            if (stage_vld)
                data_in <= stage_dat;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            data_in       <= '0;
            data_in_valid <= 1'b0;
        end else begin
            data_in_valid <= capture;
            if (capture)
                data_in <= sample_dat;
        end
    end
`endif

endmodule

// File: rtl/qspi_io_phy.sv
// QSPI/OSPI pad controller: lane drive, direction FSM with turnaround, masked read capture.
// Pads update on the drive_edge clock; read data 1 cycle after sample_edge (2 with QSPI_IO_SAMPLE_PIPE_EN).
// No backpressure: timing is fully dictated by drive_edge/sample_edge from the clock generator.
module qspi_io_phy
    import qspi_pkg::*;
#(
    parameter int IO_WIDTH = 4,
    parameter int TA_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                drive_edge,
    input  logic                sample_edge,
    input  logic [2:0]          mode,
    input  logic                dir,
    input  logic [TA_W-1:0]     ta_cycles,
    input  logic [IO_WIDTH-1:0] data_out,
    inout  wire  [IO_WIDTH-1:0] io,
    output logic [IO_WIDTH-1:0] data_in,
    output logic                data_in_valid,
    output logic                dir_ack,
    output logic                mode_err
);

    io_state_t           state_q, state_d;
    logic [IO_WIDTH-1:0] io_out_q, io_out_d;
    logic [IO_WIDTH-1:0] io_oe_q, io_oe_d;
    logic [IO_WIDTH-1:0] mask_q, mask_d, mask_new;
    logic [TA_W-1:0]     ta_cnt_q, ta_cnt_d;
    logic                mode_err_q, mode_err_d;

    assign mask_new = IO_WIDTH'(mode_to_mask(mode, IO_WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            io_out_q   <= '0;
            io_oe_q    <= '0;
            mask_q     <= '0;
            ta_cnt_q   <= '0;
            mode_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            io_out_q   <= io_out_d;
            io_oe_q    <= io_oe_d;
            mask_q     <= mask_d;
            ta_cnt_q   <= ta_cnt_d;
            mode_err_q <= mode_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        io_out_d   = io_out_q;
        io_oe_d    = io_oe_q;
        mask_d     = mask_q;
        ta_cnt_d   = ta_cnt_q;
        mode_err_d = mode_err_q;
        if (drive_edge) begin
            mask_d     = mask_new;
            mode_err_d = !mode_is_valid(mode, IO_WIDTH);
            io_out_d   = '0;
            io_oe_d    = '0;
            case (state_q)
                ST_IDLE: begin
                    if (en)
                        state_d = (dir == DIR_READ) ? ST_READ : ST_WRITE;
                end
                ST_WRITE, ST_READ: begin
                    if (!en) begin
                        state_d = ST_IDLE;
                    end else if ((state_q == ST_WRITE) != (dir == DIR_WRITE)) begin
                        // Direction change: zero turnaround swaps straight over.
                        if (ta_cycles == '0) begin
                            state_d = (dir == DIR_READ) ? ST_READ : ST_WRITE;
                        end else begin
                            state_d  = ST_TURN;
                            ta_cnt_d = ta_cycles - TA_W'(1);
                        end
                    end
                end
                ST_TURN: begin
                    if (!en)
                        state_d = ST_IDLE;
                    else if (ta_cnt_q == '0)
                        state_d = (dir == DIR_READ) ? ST_READ : ST_WRITE;
                    else
                        ta_cnt_d = ta_cnt_q - TA_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
            // Lanes are driven on every edge that lands in (or stays in) WRITE.
            if (state_d == ST_WRITE) begin
                io_out_d = data_out & mask_new;
                io_oe_d  = mask_new;
            end
        end
    end

    for (genvar i = 0; i < IO_WIDTH; i++) begin : g_pad
        assign io[i] = io_oe_q[i] ? io_out_q[i] : 1'bz;
    end

    assign dir_ack  = ((state_q == ST_WRITE) && (dir == DIR_WRITE)) ||
                      ((state_q == ST_READ)  && (dir == DIR_READ));
    assign mode_err = mode_err_q;

    // Capture sees the pre-update state and mask when both edges coincide.
    qspi_io_capture #(
        .W (IO_WIDTH)
    ) u_capture (
        .clk           (clk),
        .reset         (reset),
        .capture       (sample_edge && (state_q == ST_READ)),
        .sample_dat    (io & mask_q),
        .data_in       (data_in),
        .data_in_valid (data_in_valid)
    );

endmodule

// File: tb/tb_qspi_io_phy.sv
// Directed table-driven bench for qspi_io_phy (4 lanes); handles QSPI_IO_SAMPLE_PIPE_EN latency.
module tb_qspi_io_phy;
    import qspi_pkg::*;

`ifdef QSPI_IO_SAMPLE_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NROWS = 27;

    typedef struct {
        logic       rst, en, de, se;
        logic [2:0] mode;
        logic       dir;
        logic [3:0] ta, dout;
        logic       drv;
        logic [3:0] dval;
        logic       chk_io;
        logic [3:0] exp_io;
        logic       exp_ack, exp_merr, exp_vld;
        logic [3:0] exp_din;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, en, drive_edge, sample_edge, dir;
    logic [2:0] mode;
    logic [3:0] ta_cycles, data_out;
    wire  [3:0] io;
    logic [3:0] data_in;
    logic       data_in_valid, dir_ack, mode_err;
    logic       tb_drv;
    logic [3:0] tb_val;

    int n_vec = 0;
    int n_err = 0;
    vec_t tab [NROWS];

    assign io = tb_drv ? tb_val : 4'bzzzz;

    always #5 clk = ~clk;

    qspi_io_phy #(.IO_WIDTH(4), .TA_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .drive_edge    (drive_edge),
        .sample_edge   (sample_edge),
        .mode          (mode),
        .dir           (dir),
        .ta_cycles     (ta_cycles),
        .data_out      (data_out),
        .io            (io),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .dir_ack       (dir_ack),
        .mode_err      (mode_err)
    );

    function automatic vec_t mk(input logic rst, en_i, de, se, input logic [2:0] md,
                                input logic dr, input logic [3:0] ta, dout,
                                input logic drv, input logic [3:0] dval,
                                input logic chk, input logic [3:0] eio,
                                input logic ack, merr, vld, input logic [3:0] din);
        vec_t v;
        v.rst = rst; v.en = en_i; v.de = de; v.se = se; v.mode = md; v.dir = dr;
        v.ta = ta; v.dout = dout; v.drv = drv; v.dval = dval; v.chk_io = chk;
        v.exp_io = eio; v.exp_ack = ack; v.exp_merr = merr; v.exp_vld = vld; v.exp_din = din;
        return v;
    endfunction

    task automatic chk(input int row, input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; en = v.en; drive_edge = v.de; sample_edge = v.se;
        mode = v.mode; dir = v.dir; ta_cycles = v.ta; data_out = v.dout;
        tb_drv = v.drv; tb_val = v.dval;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t hv;
        reset = 1'b1; en = 1'b0; drive_edge = 1'b0; sample_edge = 1'b0; dir = 1'b0;
        mode = MODE_ZERO; ta_cycles = '0; data_out = '0; tb_drv = 1'b0; tb_val = '0;

        //            rst en de se mode        dir ta    dout   drv dval  chk eio   ack merr vld din
        tab[0]  = mk(1, 0, 0, 0, MODE_ZERO,   0, 4'd0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 4'h0);
        tab[1]  = mk(0, 1, 1, 0, MODE_QUAD,   0, 4'd0, 4'hA, 0, 4'h0, 1, 4'hA, 1, 0, 0, 4'h0);
        tab[2]  = mk(0, 1, 0, 0, MODE_QUAD,   0, 4'd0, 4'hA, 0, 4'h0, 1, 4'hA, 1, 0, 0, 4'h0);
        tab[3]  = mk(0, 1, 1, 0, MODE_QUAD,   0, 4'd0, 4'hA, 0, 4'h0, 1, 4'hA, 1, 0, 0, 4'h0);
        tab[4]  = mk(0, 1, 1, 0, MODE_QUAD,   0, 4'd0, 4'h5, 0, 4'h0, 1, 4'h5, 1, 0, 0, 4'h0);
        tab[5]  = mk(0, 1, 1, 0, MODE_QUAD,   1, 4'd2, 4'h5, 1, 4'hC, 1, 4'hC, 0, 0, 0, 4'h0);
        tab[6]  = mk(0, 1, 0, 0, MODE_QUAD,   1, 4'd2, 4'h5, 1, 4'hC, 1, 4'hC, 0, 0, 0, 4'h0);
        tab[7]  = mk(0, 1, 1, 0, MODE_QUAD,   1, 4'd2, 4'h5, 1, 4'hC, 1, 4'hC, 0, 0, 0, 4'h0);
        tab[8]  = mk(0, 1, 1, 0, MODE_QUAD,   1, 4'd2, 4'h5, 1, 4'hC, 1, 4'hC, 1, 0, 0, 4'h0);
        tab[9]  = mk(0, 1, 1, 0, MODE_DUAL,   1, 4'd2, 4'h5, 1, 4'hF, 1, 4'hF, 1, 0, 0, 4'h0);
        tab[10] = mk(0, 1, 0, 1, MODE_DUAL,   1, 4'd2, 4'h5, 1, 4'hF, 1, 4'hF, 1, 0, 1, 4'h3);
        tab[11] = mk(0, 1, 0, 0, MODE_DUAL,   1, 4'd2, 4'h5, 1, 4'hF, 1, 4'hF, 1, 0, 0, 4'h3);
        tab[12] = mk(0, 1, 1, 1, MODE_QUAD,   1, 4'd2, 4'h5, 1, 4'hE, 1, 4'hE, 1, 0, 1, 4'h2);
        tab[13] = mk(0, 1, 0, 1, MODE_QUAD,   1, 4'd2, 4'h5, 1, 4'hE, 1, 4'hE, 1, 0, 1, 4'hE);
        tab[14] = mk(0, 1, 0, 0, MODE_QUAD,   1, 4'd2, 4'h5, 1, 4'hE, 1, 4'hE, 1, 0, 0, 4'hE);
        tab[15] = mk(0, 1, 1, 0, MODE_QUAD,   0, 4'd2, 4'h6, 1, 4'h9, 1, 4'h9, 0, 0, 0, 4'hE);
        tab[16] = mk(0, 1, 0, 1, MODE_QUAD,   0, 4'd2, 4'h6, 1, 4'h9, 1, 4'h9, 0, 0, 0, 4'hE);
        tab[17] = mk(0, 1, 1, 0, MODE_QUAD,   0, 4'd2, 4'h6, 1, 4'h9, 1, 4'h9, 0, 0, 0, 4'hE);
        tab[18] = mk(0, 1, 1, 0, MODE_QUAD,   0, 4'd2, 4'h6, 0, 4'h0, 1, 4'h6, 1, 0, 0, 4'hE);
        tab[19] = mk(0, 1, 1, 0, MODE_QUAD,   1, 4'd0, 4'h6, 1, 4'h3, 1, 4'h3, 1, 0, 0, 4'hE);
        tab[20] = mk(0, 1, 1, 0, MODE_QUAD,   0, 4'd0, 4'hC, 0, 4'h0, 1, 4'hC, 1, 0, 0, 4'hE);
        tab[21] = mk(0, 1, 1, 0, MODE_OCTAL,  0, 4'd0, 4'hC, 1, 4'h5, 1, 4'h5, 1, 1, 0, 4'hE);
        tab[22] = mk(0, 1, 1, 0, 3'b111,      0, 4'd0, 4'hC, 1, 4'h5, 1, 4'h5, 1, 1, 0, 4'hE);
        tab[23] = mk(0, 1, 1, 0, MODE_QUAD,   0, 4'd0, 4'hC, 0, 4'h0, 1, 4'hC, 1, 0, 0, 4'hE);
        tab[24] = mk(0, 1, 1, 0, MODE_QUAD,   1, 4'd3, 4'hC, 1, 4'h5, 1, 4'h5, 0, 0, 0, 4'hE);
        tab[25] = mk(0, 0, 1, 0, MODE_QUAD,   1, 4'd3, 4'hC, 1, 4'h5, 1, 4'h5, 0, 0, 0, 4'hE);
        tab[26] = mk(0, 1, 1, 0, MODE_QUAD,   0, 4'd3, 4'h9, 0, 4'h0, 1, 4'h9, 1, 0, 0, 4'hE);

        for (int i = 0; i < NROWS; i++) begin
            int   k;
            logic ev;
            logic [3:0] ed;
            drive(tab[i]);
            k  = i - (LAT - 1);
            ev = (k >= 0) ? tab[k].exp_vld : 1'b0;
            ed = (k >= 0) ? tab[k].exp_din : 4'h0;
            if (tab[i].chk_io)
                chk(i, "io", io, tab[i].exp_io);
            chk(i, "dir_ack", {3'b0, dir_ack}, {3'b0, tab[i].exp_ack});
            chk(i, "mode_err", {3'b0, mode_err}, {3'b0, tab[i].exp_merr});
            chk(i, "data_in_valid", {3'b0, data_in_valid}, {3'b0, ev});
            chk(i, "data_in", data_in, ed);
        end

        // Invalid mode while writing, back to QUAD, then reset mid-WRITE.
        hv = mk(0, 1, 1, 0, 3'b111, 0, 4'd0, 4'h9, 1, 4'h6, 1, 4'h6, 1, 1, 0, 4'hE);
        drive(hv);
        chk(100, "io", io, 4'h6);
        chk(100, "mode_err", {3'b0, mode_err}, 4'h1);
        hv = mk(0, 1, 1, 0, MODE_QUAD, 0, 4'd0, 4'h9, 0, 4'h0, 1, 4'h9, 1, 0, 0, 4'hE);
        drive(hv);
        chk(101, "io", io, 4'h9);
        chk(101, "mode_err", {3'b0, mode_err}, 4'h0);
        hv = mk(1, 1, 1, 1, 3'b111, 0, 4'd0, 4'h9, 1, 4'h6, 1, 4'h6, 0, 0, 0, 4'h0);
        drive(hv);
        chk(102, "io", io, 4'h6);
        chk(102, "dir_ack", {3'b0, dir_ack}, 4'h0);
        chk(102, "mode_err", {3'b0, mode_err}, 4'h0);
        chk(102, "data_in_valid", {3'b0, data_in_valid}, 4'h0);
        chk(102, "data_in", data_in, 4'h0);
        // Out of reset with no drive_edge: must stay idle and released.
        hv = mk(0, 1, 0, 0, MODE_QUAD, 0, 4'd0, 4'h9, 1, 4'h6, 1, 4'h6, 0, 0, 0, 4'h0);
        drive(hv);
        chk(103, "io", io, 4'h6);
        chk(103, "dir_ack", {3'b0, dir_ack}, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
